// File: rtl/gray_pkg.sv
// ---------------------------------------------------------------------------
// gray_pkg : shared types and helpers for the gray-code decoder
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package gray_pkg;

  localparam int DEF_CBITS = 8;

  localparam logic [0:0] ST_ACQ   = 1'b0;
  localparam logic [0:0] ST_TRACK = 1'b1;

  typedef enum logic [0:0] {
    ACQ   = ST_ACQ,
    TRACK = ST_TRACK
  } state_e;

  // Reference conversion at the default width, for checkers that need a function form
  function automatic logic [DEF_CBITS-1:0] gray2bin_fn(input logic [DEF_CBITS-1:0] g);
    logic [DEF_CBITS-1:0] b;
    b[DEF_CBITS-1] = g[DEF_CBITS-1];
    for (int i = DEF_CBITS - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gray2bin.sv
// ---------------------------------------------------------------------------
// gray2bin : combinational gray-to-binary prefix XOR
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gray2bin
  import gray_pkg::*;
#(
  parameter int W = DEF_CBITS
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  generate
    for (genvar i = 0; i < W; i++) begin : g_bit
      assign bin[i] = ^gray[W-1:i];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/gray_dec.sv
// ---------------------------------------------------------------------------
// gray_dec : gray-coded counter receiver with step checking and lock tracking
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gray_dec
  import gray_pkg::*;
#(
  parameter int CBITS  = DEF_CBITS,
  parameter int LOCK_N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CBITS-1:0] gray_in,
  input  logic             gray_vld,
  output logic [CBITS-1:0] bin_out,
  output logic             bin_vld,
  output logic             wrap,
  output logic             step_err,
  output logic             err_sticky,
  output logic [7:0]       err_cnt,
  output logic             locked
);

  localparam logic [3:0]       LOCK_MAX = LOCK_N[3:0];
  localparam logic [CBITS-1:0] ONE      = {{(CBITS-1){1'b0}}, 1'b1};

  state_e           state;
  logic [CBITS-1:0] prev;
  logic [3:0]       run;

  logic [CBITS-1:0] dec;
  logic [CBITS-1:0] prev_inc;
  logic [3:0]       run_inc;
  logic             is_hold;
  logic             is_step;

  gray2bin #(.W(CBITS)) u_gray2bin (
    .gray (gray_in),
    .bin  (dec)
  );

  assign prev_inc = prev + ONE;
  assign is_hold  = (dec == prev);
  assign is_step  = (dec == prev_inc);
  assign run_inc  = (run == LOCK_MAX) ? run : run + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACQ;
      prev       <= '0;
      bin_out    <= '0;
      bin_vld    <= 1'b0;
      wrap       <= 1'b0;
      step_err   <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= 8'd0;
      run        <= 4'd0;
      locked     <= 1'b0;
    end else begin
      bin_vld  <= 1'b0;
      wrap     <= 1'b0;
      step_err <= 1'b0;
      if (gray_vld) begin
        bin_vld <= 1'b1;
        bin_out <= dec;
        // prev always follows the accepted sample, which also resyncs after an error
        prev    <= dec;
        if (state == ACQ) begin
          state  <= TRACK;
          run    <= 4'd0;
          locked <= 1'b0;
        end else if (is_hold) begin
          run <= run;
        end else if (is_step) begin
          run    <= run_inc;
          locked <= (run_inc == LOCK_MAX);
          wrap   <= &prev;
        end else begin
          step_err   <= 1'b1;
          err_sticky <= 1'b1;
          if (err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
          end
          run    <= 4'd0;
          locked <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gray_dec.sv
// ---------------------------------------------------------------------------
// tb_gray_dec : table-driven and sequence checks for gray_dec
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_gray_dec;

  logic       clk;
  logic       rst_n;
  logic [7:0] gray_in;
  logic       gray_vld;
  logic [7:0] bin_out;
  logic       bin_vld;
  logic       wrap;
  logic       step_err;
  logic       err_sticky;
  logic [7:0] err_cnt;
  logic       locked;

  int checks = 0;
  int errors = 0;

  gray_dec #(.CBITS(8), .LOCK_N(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gray_in    (gray_in),
    .gray_vld   (gray_vld),
    .bin_out    (bin_out),
    .bin_vld    (bin_vld),
    .wrap       (wrap),
    .step_err   (step_err),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt),
    .locked     (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [7:0] g;
    logic [7:0] bin;
    logic       bv;
    logic       wr;
    logic       se;
    logic       lk;
    logic       stk;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic apply(input logic vld, input logic [7:0] g);
    @(negedge clk);
    gray_vld = vld;
    gray_in  = g;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bin_out"}, int'(bin_out), 0);
    chk({tag, "_bin_vld"}, int'(bin_vld), 0);
    chk({tag, "_wrap"}, int'(wrap), 0);
    chk({tag, "_step_err"}, int'(step_err), 0);
    chk({tag, "_sticky"}, int'(err_sticky), 0);
    chk({tag, "_err_cnt"}, int'(err_cnt), 0);
    chk({tag, "_locked"}, int'(locked), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n    = 1'b0;
    gray_vld = 1'b0;
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] bin2gray(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  initial begin
    int nwrap;
    int wrap_bad;
    int bin_bad;
    int nerr;
    int nvld;
    int hold_bad;
    logic [7:0] b;

    //              vld  gray   bin  bv wr se lk stk cnt
    tbl[0]  = '{1'b1, 8'h00, 8'd0,  1, 0, 0, 0, 0, 8'd0};
    tbl[1]  = '{1'b1, 8'h01, 8'd1,  1, 0, 0, 0, 0, 8'd0};
    tbl[2]  = '{1'b1, 8'h03, 8'd2,  1, 0, 0, 0, 0, 8'd0};
    tbl[3]  = '{1'b1, 8'h02, 8'd3,  1, 0, 0, 0, 0, 8'd0};
    tbl[4]  = '{1'b1, 8'h06, 8'd4,  1, 0, 0, 1, 0, 8'd0};
    tbl[5]  = '{1'b1, 8'h0D, 8'd9,  1, 0, 1, 0, 1, 8'd1};
    tbl[6]  = '{1'b1, 8'h0F, 8'd10, 1, 0, 0, 0, 1, 8'd1};
    tbl[7]  = '{1'b1, 8'h0E, 8'd11, 1, 0, 0, 0, 1, 8'd1};
    tbl[8]  = '{1'b1, 8'h0A, 8'd12, 1, 0, 0, 0, 1, 8'd1};
    tbl[9]  = '{1'b1, 8'h0B, 8'd13, 1, 0, 0, 1, 1, 8'd1};
    tbl[10] = '{1'b1, 8'h0B, 8'd13, 1, 0, 0, 1, 1, 8'd1};
    tbl[11] = '{1'b0, 8'hFF, 8'd13, 0, 0, 0, 1, 1, 8'd1};
    tbl[12] = '{1'b1, 8'h09, 8'd14, 1, 0, 0, 1, 1, 8'd1};
    tbl[13] = '{1'b1, 8'h0C, 8'd8,  1, 0, 1, 0, 1, 8'd2};

    rst_n    = 1'b0;
    gray_vld = 1'b0;
    gray_in  = 8'h00;
    #12;
    chk_all_zero("por");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      apply(tbl[i].vld, tbl[i].g);
      chk($sformatf("v%0d_bin_out", i), int'(bin_out), int'(tbl[i].bin));
      chk($sformatf("v%0d_bin_vld", i), int'(bin_vld), int'(tbl[i].bv));
      chk($sformatf("v%0d_wrap", i), int'(wrap), int'(tbl[i].wr));
      chk($sformatf("v%0d_step_err", i), int'(step_err), int'(tbl[i].se));
      chk($sformatf("v%0d_locked", i), int'(locked), int'(tbl[i].lk));
      chk($sformatf("v%0d_sticky", i), int'(err_sticky), int'(tbl[i].stk));
      chk($sformatf("v%0d_err_cnt", i), int'(err_cnt), int'(tbl[i].cnt));
    end

    // Full sweep across the 255->0 boundary
    do_reset();
    nwrap = 0; wrap_bad = 0; bin_bad = 0; nerr = 0;
    for (int i = 0; i < 256; i++) begin
      b = 8'(250 + i);
      apply(1'b1, bin2gray(b));
      if (bin_out != b) bin_bad++;
      if (step_err) nerr++;
      if (wrap) begin
        nwrap++;
        if (bin_out != 8'd0) wrap_bad++;
      end
    end
    chk("sweep_bin_mismatches", bin_bad, 0);
    chk("sweep_wrap_count", nwrap, 1);
    chk("sweep_wrap_position", wrap_bad, 0);
    chk("sweep_step_errs", nerr, 0);
    chk("sweep_err_cnt", int'(err_cnt), 0);
    chk("sweep_locked", int'(locked), 1);

    // Mid-stream reset then far-away acquire
    do_reset();
    apply(1'b1, bin2gray(8'd100));
    chk("reacq_bin_out", int'(bin_out), 100);
    chk("reacq_bin_vld", int'(bin_vld), 1);
    chk("reacq_step_err", int'(step_err), 0);
    chk("reacq_sticky", int'(err_sticky), 0);

    // Repeated binary 7 with gaps
    do_reset();
    nvld = 0; hold_bad = 0; nerr = 0;
    apply(1'b1, bin2gray(8'd7));
    if (bin_vld) nvld++;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 8'hA5);
      if (bin_vld) nvld++;
      if (bin_out != 8'd7) hold_bad++;
    end
    apply(1'b1, bin2gray(8'd7));
    if (bin_vld) nvld++;
    if (step_err) nerr++;
    chk("hold_bin_vld_pulses", nvld, 2);
    chk("hold_gap_bin_out", hold_bad, 0);
    chk("hold_step_err", nerr, 0);
    chk("hold_bin_out", int'(bin_out), 7);
    chk("hold_sticky", int'(err_sticky), 0);

    // 300 consecutive errors: alternate 0 and 128 from prev = 7
    nerr = 0;
    for (int i = 0; i < 300; i++) begin
      apply(1'b1, (i % 2 == 0) ? bin2gray(8'd0) : bin2gray(8'd128));
      if (step_err) nerr++;
    end
    chk("sat_step_err_pulses", nerr, 300);
    chk("sat_err_cnt", int'(err_cnt), 255);
    chk("sat_sticky", int'(err_sticky), 1);
    chk("sat_locked", int'(locked), 0);
    apply(1'b0, 8'h00);
    chk("sat_idle_step_err", int'(step_err), 0);
    chk("sat_idle_err_cnt", int'(err_cnt), 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
